// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared constants for the Hack CPU control path.
//   - Jump-field encodings of the C-instruction {j1,j2,j3} = {<0, =0, >0}.
//   - Program-counter state encoding (RUN / HALT).
// No ports; imported with "import hack_pkg::*;".
// -----------------------------------------------------------------------------
package hack_pkg;

    // Jump field {j1,j2,j3}
    localparam logic [2:0] JNULL = 3'b000;  // never jump
    localparam logic [2:0] JGT   = 3'b001;  // jump if out >  0
    localparam logic [2:0] JEQ   = 3'b010;  // jump if out == 0
    localparam logic [2:0] JGE   = 3'b011;  // jump if out >= 0
    localparam logic [2:0] JLT   = 3'b100;  // jump if out <  0
    localparam logic [2:0] JNE   = 3'b101;  // jump if out != 0
    localparam logic [2:0] JLE   = 3'b110;  // jump if out <= 0
    localparam logic [2:0] JMP   = 3'b111;  // always jump

    // Program-counter state encoding
    localparam logic [0:0] PC_RUN  = 1'b0;
    localparam logic [0:0] PC_HALT = 1'b1;

endpackage

// File: rtl/jump_cond.sv
// -----------------------------------------------------------------------------
// jump_cond
// Combinational jump-condition evaluation for a Hack C-instruction.
// Ports:
//   jmp        in  3  jump bits {j1,j2,j3} = {<0, =0, >0}
//   zr         in  1  ALU out == 0
//   ng         in  1  ALU out < 0
//   is_c_instr in  1  current instruction is a C-instruction
//   take       out 1  jump is taken
// -----------------------------------------------------------------------------
module jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    input  logic       is_c_instr,
    output logic       take
);

    logic pos;
    logic cond;

    // "Positive" is derived literally from the flags, so the illegal zr=ng=1
    // combination gives the same answer as the sum-of-products form
    // (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr).
    assign pos = ~ng & ~zr;

    always_comb begin
        cond = 1'b0;
        case (jmp)
            JNULL:   cond = 1'b0;
            JGT:     cond = pos;
            JEQ:     cond = zr;
            JGE:     cond = zr | pos;
            JLT:     cond = ng;
            JNE:     cond = ng | pos;
            JLE:     cond = ng | zr;
            JMP:     cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // A-instructions carry an address in the jump-bit positions; never jump on them.
    assign take = is_c_instr & cond;

endmodule

// File: rtl/hack_pc.sv
// -----------------------------------------------------------------------------
// hack_pc
// Hack CPU program counter with jump-condition evaluation, stall support and
// detection of the "jump to self" halt idiom ((END) @END; 0;JMP).
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   PC_RUN  | normal fetch: pc advances by 1 or loads a_reg on a taken jump
//   PC_HALT | taken jump to own address seen; pc frozen until rst
//
// Parameters:
//   WIDTH        PC / A-register width in bits
//   RESET_VECTOR pc value loaded on reset
//   HALT_DETECT  1 = enter HALT on a taken jump to self; 0 = never halt
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous, active-high reset
//   en         in  1      advance enable; 0 = stall (hold all state)
//   is_c_instr in  1      current instruction is a C-instruction
//   jmp        in  3      jump bits {j1,j2,j3}
//   zr         in  1      ALU out == 0
//   ng         in  1      ALU out < 0
//   a_reg      in  WIDTH  jump target
//   pc         out WIDTH  address of the instruction to fetch
//   jump_taken out 1      registered pulse: last advance was a jump
//   halted     out 1      1 while in HALT
// -----------------------------------------------------------------------------
module hack_pc
    import hack_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter bit               HALT_DETECT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             is_c_instr,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] pc,
    output logic             jump_taken,
    output logic             halted
);

    logic [0:0] state;
    logic       take;
    logic       self_jump;

    jump_cond u_jump_cond (
        .jmp        (jmp),
        .zr         (zr),
        .ng         (ng),
        .is_c_instr (is_c_instr),
        .take       (take)
    );

    // Only meaningful when qualified by en & take in RUN.
    assign self_jump = HALT_DETECT && (a_reg == pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            jump_taken <= 1'b0;
            state      <= PC_RUN;
        end else begin
            case (state)
                PC_RUN: begin
                    if (en) begin
                        if (take) begin
                            pc         <= a_reg;
                            jump_taken <= 1'b1;
                            if (self_jump) begin
                                state <= PC_HALT;
                            end
                        end else begin
                            // natural modulo-2^WIDTH wrap
                            pc         <= pc + WIDTH'(1);
                            jump_taken <= 1'b0;
                        end
                    end
                end
                PC_HALT: begin
                    // pc frozen; the entry pulse on jump_taken ends here
                    jump_taken <= 1'b0;
                end
                default: begin
                    jump_taken <= 1'b0;
                    state      <= PC_RUN;
                end
            endcase
        end
    end

    // Straight from the state flop: no combinational path from inputs.
    assign halted = (state == PC_HALT);

endmodule

// File: tb/tb_hack_pc.sv
module tb_hack_pc;

    logic        clk = 1'b0;
    logic        rst, en, is_c, zr, ng;
    logic [2:0]  jmp;
    logic [15:0] a_reg;

    logic [15:0] pc0, pc1;
    logic        jt0, jt1, h0, h1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: index 0 = halt detection on, 1 = off
    int m_pc [2];
    bit m_jt [2];
    bit m_h  [2];

    always #5 clk = ~clk;

    hack_pc #(.WIDTH(16), .RESET_VECTOR(16'h0000), .HALT_DETECT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .is_c_instr(is_c), .jmp(jmp),
        .zr(zr), .ng(ng), .a_reg(a_reg),
        .pc(pc0), .jump_taken(jt0), .halted(h0)
    );

    hack_pc #(.WIDTH(16), .RESET_VECTOR(16'h0000), .HALT_DETECT(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .en(en), .is_c_instr(is_c), .jmp(jmp),
        .zr(zr), .ng(ng), .a_reg(a_reg),
        .pc(pc1), .jump_taken(jt1), .halted(h1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level jump rule: jump when the ALU result's sign class is selected.
    function automatic bit cond_of(input logic [2:0] j, input logic z, input logic n);
        bit lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
    endfunction

    task automatic model_update();
        bit t;
        t = is_c && cond_of(jmp, zr, ng);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = 0; m_jt[k] = 0; m_h[k] = 0;
            end else if (m_h[k]) begin
                m_jt[k] = 0;
            end else if (en) begin
                if (t) begin
                    if (k == 0 && int'(a_reg) == m_pc[k]) m_h[k] = 1;
                    m_pc[k] = int'(a_reg);
                    m_jt[k] = 1;
                end else begin
                    m_pc[k] = (m_pc[k] + 1) % 65536;
                    m_jt[k] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_pc_hd",   32'(pc0), 32'(m_pc[0]));
        chk("model_jt_hd",   32'(jt0), 32'(m_jt[0]));
        chk("model_halt_hd", 32'(h0),  32'(m_h[0]));
        chk("model_pc_nh",   32'(pc1), 32'(m_pc[1]));
        chk("model_jt_nh",   32'(jt1), 32'(m_jt[1]));
        chk("model_halt_nh", 32'(h1),  32'(m_h[1]));
    endtask

    task automatic jump_to(input logic [15:0] addr);
        rst = 0; en = 1; is_c = 1; jmp = 3'b111; zr = 0; ng = 0; a_reg = addr;
        step();
    endtask

    typedef struct {
        logic [2:0]  jmp;
        logic        zr;
        logic        ng;
        logic        is_c;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t       tbl [25];
    logic [7:0] masks [3];
    logic [1:0] flags [3];

    initial begin
        // Jump-table expectations: bit j of the mask = jump for jmp=j.
        // positive -> any j3 set; zero -> any j2 set; negative -> any j1 set
        masks[0] = 8'hAA; flags[0] = 2'b00;
        masks[1] = 8'hCC; flags[1] = 2'b10;
        masks[2] = 8'hF0; flags[2] = 2'b01;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) begin
                tbl[f*8+j].jmp    = 3'(j);
                tbl[f*8+j].zr     = flags[f][1];
                tbl[f*8+j].ng     = flags[f][0];
                tbl[f*8+j].is_c   = 1'b1;
                tbl[f*8+j].exp_pc = masks[f][j] ? 16'h0040 : 16'h0006;
            end
        end
        tbl[24] = '{jmp: 3'b111, zr: 1'b0, ng: 1'b0, is_c: 1'b0, exp_pc: 16'h0006};

        // Reset with a taken jump pending
        rst = 1; en = 1; is_c = 1; jmp = 3'b111; zr = 0; ng = 0; a_reg = 16'h0040;
        step();
        step();
        chk("reset_pc", 32'(pc0), 32'h0);
        chk("reset_jt", 32'(jt0), 32'h0);
        chk("reset_halted", 32'(h0), 32'h0);
        rst = 0; jmp = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("count_after_reset", 32'(pc0), 32'(i));
        end

        // Full jump table
        for (int i = 0; i < 25; i++) begin
            jump_to(16'h0005);
            jmp = tbl[i].jmp; zr = tbl[i].zr; ng = tbl[i].ng; is_c = tbl[i].is_c;
            a_reg = 16'h0040;
            step();
            chk($sformatf("jtab_pc[%0d]", i), 32'(pc0), 32'(tbl[i].exp_pc));
            chk($sformatf("jtab_jt[%0d]", i), 32'(jt0), 32'(tbl[i].exp_pc == 16'h0040));
        end

        // Stall holds pc and jump_taken
        jump_to(16'h0030);
        chk("stall_pre_jt", 32'(jt0), 32'h1);
        en = 0; jmp = 3'b111; is_c = 1; a_reg = 16'h0050;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc0), 32'h0030);
            chk("stall_jt", 32'(jt0), 32'h1);
        end
        en = 1;
        step();
        chk("stall_release_pc", 32'(pc0), 32'h0050);

        // Wrap-around
        jump_to(16'hFFFE);
        jmp = 3'b000;
        step();
        chk("wrap_ffff", 32'(pc0), 32'hFFFF);
        step();
        chk("wrap_0000", 32'(pc0), 32'h0000);
        chk("wrap_jt", 32'(jt0), 32'h0);

        // Halt on jump-to-self
        jump_to(16'h0010);
        a_reg = 16'h0010;
        step();
        chk("halt_entry_pc", 32'(pc0), 32'h0010);
        chk("halt_entry_jt", 32'(jt0), 32'h1);
        chk("halt_entry_halted", 32'(h0), 32'h1);
        chk("nohalt_halted", 32'(h1), 32'h0);
        step();
        chk("halt_pc_frozen", 32'(pc0), 32'h0010);
        chk("halt_jt_cleared", 32'(jt0), 32'h0);
        chk("nohalt_loop_pc", 32'(pc1), 32'h0010);
        chk("nohalt_loop_jt", 32'(jt1), 32'h1);
        a_reg = 16'h0020;
        step();
        chk("halt_ignores_inputs", 32'(pc0), 32'h0010);
        chk("halt_still", 32'(h0), 32'h1);
        chk("nohalt_follows", 32'(pc1), 32'h0020);
        rst = 1;
        step();
        chk("halt_reset_pc", 32'(pc0), 32'h0);
        chk("halt_reset_halted", 32'(h0), 32'h0);

        // Reset in the same cycle as a taken jump
        jump_to(16'h0022);
        rst = 1; jmp = 3'b111; is_c = 1; a_reg = 16'h0040;
        step();
        chk("rst_mid_jump_pc", 32'(pc0), 32'h0);
        chk("rst_mid_jump_jt", 32'(jt0), 32'h0);

        // Reset winning over a halt condition
        rst = 0;
        jump_to(16'h0007);
        rst = 1; a_reg = 16'h0007;
        step();
        chk("rst_vs_halt", 32'(h0), 32'h0);

        // Randomized run against the reference model
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            rst  = ($urandom_range(0, 99) < 3);
            en   = ($urandom_range(0, 9) != 0);
            is_c = ($urandom_range(0, 3) != 0);
            jmp  = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r == 0)      {zr, ng} = 2'b11;
            else if (r < 4)  {zr, ng} = 2'b10;
            else if (r < 7)  {zr, ng} = 2'b01;
            else             {zr, ng} = 2'b00;
            r = $urandom_range(0, 9);
            if (r == 0)      a_reg = 16'(m_pc[0]);
            else if (r == 1) a_reg = 16'(m_pc[1]);
            else             a_reg = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
